bp_unit: RTL
============

Name: bp_unit

Overview:
Parametrised, memory-mapped hardware breakpoint unit. It is the next generation of the fixed four-breakpoint register block in the CPU memory map.
- Supports NUM_BP channels.
- Each channel matches instruction fetch, data read or data write.
- Provides per-channel hit counters, sticky status, a halt request and a latency-configurable bus handshake.
- Sits beside the RAM decoder on the CPU data bus and watches the fetch and data address streams.

Parameters:
NUM_BP, 4, number of breakpoint channels (1..8)
BASE_ADDR, 32'hFFFFF000, word address of the register window (aligned to 64 words)
READ_LAT, 1, cycles from re to ready (0..3)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
addr  in  32  bus word address
write  in  16  bus write data
we  in  1  bus write strobe
re  in  1  bus read strobe
read  out  16  bus read data; 0 when sel=0
ready  out  1  bus read handshake
sel  out  1  combinational: addr in [BASE_ADDR, BASE_ADDR+63] and (re|we)
pc  in  32  fetch address
pcValid  in  1  fetch in progress this cycle
dataAddr  in  32  load/store address
dataRe  in  1  load this cycle
dataWe  in  1  store this cycle
halt  out  1  breakpoint halt request to the control unit
hitIdx  out  3  lowest-index channel that set halt

Behaviour:
- Register map, word offsets from BASE_ADDR. Channel k occupies 8*k .. 8*k+7:
  - +0 CTRL: bit0 enable; bits2:1 mode (00 exec on pc, 01 store, 10 load, 11 load or store). Other bits read 0.
  - +1 ADDR_LO, +2 ADDR_HI.
  - +3 COUNT: hit count, read-only, saturates at 16'hFFFF; any write clears it to 0.
  - +4/+5: mask (optional feature); +6/+7 reserved.
- Global registers at 8*NUM_BP:
  - +0 STATUS: bit k = sticky hit for channel k. Write-1-to-clear.
  - +1/+2 LAST_LO/HI: address that caused the most recent halt-setting hit.
- Unmapped offsets inside the window read 0; writes to them are ignored.
- Match (combinational), channel k: enable, and the selected stream's strobe is high, and stream address == {ADDR_HI, ADDR_LO}.
  - Exec mode uses pc/pcValid.
  - Data modes use dataAddr with dataRe/dataWe.
- On any match, registered on the next posedge:
  - STATUS[k] set; COUNT[k] incremented (saturating).
  - If halt was 0: halt <= 1, hitIdx <= lowest matching k, LAST <= that channel's stream address.
  - While halt=1, later hits update STATUS and COUNT only.
- halt clears on the edge after STATUS becomes all-zero through a W1C write.
- Same-cycle W1C of bit k and a new match on k: the set wins; STATUS[k] stays 1.
- Same-cycle bus write to CTRL/ADDR and a match on that channel: the match uses the old register values.
- Read handshake:
  - re captured into a READ_LAT-deep shift register; ready = output of the last stage.
  - READ_LAT=0 gives ready = re & sel, combinationally.
  - read data is sampled on the re cycle and held until ready.
  - re held high re-arms each cycle, pipelined one result per cycle.
  - ready never asserts for out-of-window addresses.
- Writes complete in the cycle of we; no handshake.
- Reset: all CTRL, ADDR, COUNT, STATUS and LAST cleared to 0; halt=0; hitIdx=0; ready=0; pipeline flushed. Reset during a pending read drops that read, with no ready.

Optional Feature:
BP_ADDR_MASK_EN
- Defined: +4 MASK_LO and +5 MASK_HI are read/write, reset 0. Match condition becomes ((stream ^ bpAddr) & ~mask) == 0, giving address-range breakpoints.
- Undefined: +4/+5 read 0, writes are ignored, and matching is exact equality.

Decomposition:
Shared package bp_pkg holds:
- Mode encodings: BP_MODE_EXEC, BP_MODE_ST, BP_MODE_LD, BP_MODE_ANY.
- Register offsets: CTRL, ADDR_LO, ADDR_HI, COUNT, MASK_LO, MASK_HI, STATUS, LAST_LO, LAST_HI.
- Channel stride constant: 8.

One sub-module, bp_channel, instantiated NUM_BP times. It contains:
- CTRL/ADDR/MASK registers, comparator and saturating counter.
- Outputs: match and readback data.

Test Plan:
- Write ch0 CTRL=1, ADDR=0x0000_0040; drive pcValid with pc=0x40 → halt=1 and hitIdx=0 next cycle; LAST=0x40, COUNT0=1, STATUS=0x0001.
- ch1 mode=01 at 0x1000_0010 and ch2 mode=11 at the same address; store to 0x1000_0010 → STATUS=0x0006, hitIdx=1, both counts=1.
- With halt=1, write STATUS=0x0002 → halt stays 1; then write 0x0004 → halt=0 one cycle later.
- W1C of bit0 in the same cycle as a new ch0 hit → STATUS[0]=1, COUNT0 increments.
- COUNT preloaded via 65535 hits → stays 0xFFFF on the next hit; a write to COUNT gives 0.
- READ_LAT=2: re on ADDR_LO of ch3 for 1 cycle → ready high exactly 2 cycles later with the correct data. Out-of-window re → sel=0, read=0, no ready. rst asserted mid-read → no ready.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the breakpoint unit: mode encodings, register offsets and the channel stride.
// Holds no logic of its own.
// Imported by bp_channel and bp_unit.
package bp_pkg;

   typedef enum logic [1:0] {
      BP_MODE_EXEC = 2'b00,   // instruction fetch on pc/pcValid
      BP_MODE_ST   = 2'b01,   // store on dataAddr/dataWe
      BP_MODE_LD   = 2'b10,   // load on dataAddr/dataRe
      BP_MODE_ANY  = 2'b11    // load or store
   } bpMode_t;

   // Channel configuration held in CTRL/ADDR_LO/ADDR_HI
   typedef struct packed {
      logic        en;
      bpMode_t     mode;
      logic [31:0] addr;
   } bpCfg_t;

   // Per-channel word offsets (within the 8-word channel slot)
   localparam logic [2:0] CTRL    = 3'd0;
   localparam logic [2:0] ADDR_LO = 3'd1;
   localparam logic [2:0] ADDR_HI = 3'd2;
   localparam logic [2:0] COUNT   = 3'd3;
   localparam logic [2:0] MASK_LO = 3'd4;
   localparam logic [2:0] MASK_HI = 3'd5;

   // Global word offsets (within the slot that follows the last channel)
   localparam logic [2:0] STATUS  = 3'd0;
   localparam logic [2:0] LAST_LO = 3'd1;
   localparam logic [2:0] LAST_HI = 3'd2;

   localparam int BP_STRIDE = 8;

   // Hit counter increment that sticks at all-ones
   function automatic logic [15:0] satInc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bp_channel.sv
// One breakpoint channel: config registers, address comparator and saturating hit counter.
// Latency: match and rdData are combinational; register writes land on the next posedge.
// Backpressure: none; writes always accepted, the comparator uses pre-write register values.
// Ports: clk/rst; wrEn/regOff/wrData bus write into this slot; regOff also selects rdData;
//        pc/pcValid, dataAddr/dataRe/dataWe watched streams; match, streamAddr (address
//        compared this cycle), rdData readback.
// Optional build macro BP_ADDR_MASK_EN adds MASK_LO/MASK_HI (set mask bits are don't-care).
module bp_channel
   import bp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wrEn,
   input  logic [2:0]  regOff,
   input  logic [15:0] wrData,
   input  logic [31:0] pc,
   input  logic        pcValid,
   input  logic [31:0] dataAddr,
   input  logic        dataRe,
   input  logic        dataWe,
   output logic        match,
   output logic [31:0] streamAddr,
   output logic [15:0] rdData
);

   bpCfg_t      cfg;
   logic [15:0] count;
   logic        strobe;
   logic [31:0] maskRd;
   logic [31:0] cmpMask;

`ifdef BP_ADDR_MASK_EN
   logic [31:0] mask;
   assign maskRd  = mask;
   assign cmpMask = ~mask;
`else
   assign maskRd  = 32'd0;
   assign cmpMask = 32'hFFFF_FFFF;
`endif

   always_comb begin
      strobe     = 1'b0;
      streamAddr = dataAddr;
      case (cfg.mode)
         BP_MODE_EXEC: begin
            strobe     = pcValid;
            streamAddr = pc;
         end
         BP_MODE_ST:  strobe = dataWe;
         BP_MODE_LD:  strobe = dataRe;
         BP_MODE_ANY: strobe = dataRe | dataWe;
         default:     strobe = 1'b0;
      endcase
   end

   assign match = cfg.en && strobe && (((streamAddr ^ cfg.addr) & cmpMask) == 32'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg   <= '0;
         count <= 16'd0;
`ifdef BP_ADDR_MASK_EN
         mask  <= 32'd0;
`endif
      end else begin
         if (match) count <= satInc(count);
         // A bus write to COUNT in the same cycle as a hit wins (clears)
         if (wrEn) begin
            case (regOff)
               CTRL: begin
                  cfg.en   <= wrData[0];
                  cfg.mode <= bpMode_t'(wrData[2:1]);
               end
               ADDR_LO: cfg.addr[15:0]  <= wrData;
               ADDR_HI: cfg.addr[31:16] <= wrData;
               COUNT:   count           <= 16'd0;
`ifdef BP_ADDR_MASK_EN
               MASK_LO: mask[15:0]      <= wrData;
               MASK_HI: mask[31:16]     <= wrData;
`endif
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdData = 16'd0;
      case (regOff)
         CTRL:    rdData = {13'd0, cfg.mode, cfg.en};
         ADDR_LO: rdData = cfg.addr[15:0];
         ADDR_HI: rdData = cfg.addr[31:16];
         COUNT:   rdData = count;
         MASK_LO: rdData = maskRd[15:0];
         MASK_HI: rdData = maskRd[31:16];
         default: rdData = 16'd0;
      endcase
   end

endmodule

// File: rtl/bp_unit.sv
// Memory-mapped hardware breakpoint unit with NUM_BP channels, sticky status and halt request.
// Latency: hits register on the next posedge; read data returns READ_LAT cycles after re (0 = same cycle).
// Backpressure: none; every in-window re produces exactly one ready, one per cycle when re is held.
// Ports: clk/rst; addr/write/we/re bus in, read/ready/sel bus out; pc/pcValid and
//        dataAddr/dataRe/dataWe watched streams; halt/hitIdx to the control unit.
// Optional build macro BP_ADDR_MASK_EN enables per-channel address masks (see bp_channel).
module bp_unit
   import bp_pkg::*;
#(
   parameter int          NUM_BP    = 4,
   parameter logic [31:0] BASE_ADDR = 32'hFFFFF000,
   parameter int          READ_LAT  = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [15:0] write,
   input  logic        we,
   input  logic        re,
   output logic [15:0] read,
   output logic        ready,
   output logic        sel,
   input  logic [31:0] pc,
   input  logic        pcValid,
   input  logic [31:0] dataAddr,
   input  logic        dataRe,
   input  logic        dataWe,
   output logic        halt,
   output logic [2:0]  hitIdx
);

   logic              inWin;
   logic [2:0]        chanSel;
   logic [2:0]        regOff;
   logic              globSel;
   logic [NUM_BP-1:0] match;
   logic [31:0]       streamAddr [NUM_BP];
   logic [15:0]       chanRd     [NUM_BP];
   logic [NUM_BP-1:0] status;
   logic [NUM_BP-1:0] statusNext;
   logic [NUM_BP-1:0] w1c;
   logic              statusWr;
   logic              clrPending;
   logic [31:0]       last;
   logic [2:0]        firstIdx;
   logic [31:0]       firstAddr;
   logic [15:0]       rdNow;
   logic              rdHit;

   assign inWin   = (addr[31:6] == BASE_ADDR[31:6]);
   assign sel     = inWin && (re || we);
   assign chanSel = addr[5:3];
   assign regOff  = addr[2:0];
   // With NUM_BP=8 the global slot falls outside the 64-word window and is unreachable
   assign globSel = ({1'b0, chanSel, 3'b000} == 7'(NUM_BP * BP_STRIDE));

   for (genvar k = 0; k < NUM_BP; k++) begin : gChan
      bp_channel uChan (
         .clk        (clk),
         .rst        (rst),
         .wrEn       (we && inWin && (chanSel == 3'(k))),
         .regOff     (regOff),
         .wrData     (write),
         .pc         (pc),
         .pcValid    (pcValid),
         .dataAddr   (dataAddr),
         .dataRe     (dataRe),
         .dataWe     (dataWe),
         .match      (match[k]),
         .streamAddr (streamAddr[k]),
         .rdData     (chanRd[k])
      );
   end

   // Lowest-index matching channel supplies hitIdx and LAST
   always_comb begin
      firstIdx  = 3'd0;
      firstAddr = 32'd0;
      for (int k = NUM_BP - 1; k >= 0; k--) begin
         if (match[k]) begin
            firstIdx  = 3'(k);
            firstAddr = streamAddr[k];
         end
      end
   end

   // Set beats write-1-to-clear when both hit the same bit
   assign statusWr   = we && inWin && globSel && (regOff == STATUS);
   assign w1c        = statusWr ? write[NUM_BP-1:0] : '0;
   assign statusNext = (status & ~w1c) | match;

   always_ff @(posedge clk) begin
      if (rst) begin
         status     <= '0;
         clrPending <= 1'b0;
         halt       <= 1'b0;
         hitIdx     <= 3'd0;
         last       <= 32'd0;
      end else begin
         status     <= statusNext;
         // halt drops one edge after a W1C write empties STATUS
         clrPending <= statusWr && (statusNext == '0);
         // A hit landing on the clearing edge re-arms halt rather than being lost
         if ((|match) && (!halt || clrPending)) begin
            halt   <= 1'b1;
            hitIdx <= firstIdx;
            last   <= firstAddr;
         end else if (clrPending) begin
            halt   <= 1'b0;
         end
      end
   end

   always_comb begin
      rdNow = 16'd0;
      if (globSel) begin
         case (regOff)
            STATUS:  rdNow = 16'(status);
            LAST_LO: rdNow = last[15:0];
            LAST_HI: rdNow = last[31:16];
            default: rdNow = 16'd0;
         endcase
      end else begin
         for (int k = 0; k < NUM_BP; k++) begin
            if (chanSel == 3'(k)) rdNow = chanRd[k];
         end
      end
   end

   assign rdHit = re && inWin;

   // Read data is captured on the re cycle and travels with its valid bit;
   // read is driven only while ready is high.
   if (READ_LAT == 0) begin : gLat0
      assign ready = rdHit;
      assign read  = rdHit ? rdNow : 16'd0;
   end else begin : gLatN
      logic [READ_LAT-1:0] vldPipe;
      logic [15:0]         datPipe [READ_LAT];

      always_ff @(posedge clk) begin
         if (rst) begin
            vldPipe <= '0;
            for (int i = 0; i < READ_LAT; i++) datPipe[i] <= 16'd0;
         end else begin
            vldPipe[0] <= rdHit;
            datPipe[0] <= rdHit ? rdNow : 16'd0;
            for (int i = 1; i < READ_LAT; i++) begin
               vldPipe[i] <= vldPipe[i-1];
               datPipe[i] <= datPipe[i-1];
            end
         end
      end

      assign ready = vldPipe[READ_LAT-1];
      assign read  = ready ? datPipe[READ_LAT-1] : 16'd0;
   end

endmodule
